fpdiv: RTL and testbench

FPDIV -- requirements
Module: fpdiv

---
 rtl/fp_pkg.sv | 45 ++++
 rtl/fpdiv_if.sv | 26 ++
 rtl/fpdiv_cu.sv | 78 +++++++
 rtl/fpdiv_dp.sv | 158 +++++++++++++++
 rtl/fpdiv.sv | 40 ++++
 tb/tb_fpdiv.sv | 385 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision divider.
// Holds the FSM encoding, result selectors and the cu/dp control and status bundles.
package fp_pkg;

  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam int ITER = 25;

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, ALIGN,
    DIV, ROUND, PACK, DONE
  } state_t;

  typedef enum logic [2:0] {
    RES_NORM, RES_NAN, RES_INF, RES_DZ,
    RES_ZERO, RES_OF, RES_UF
  } res_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic divzero;
    logic lt;
    logic cnt_zero;
    logic carry;
    logic uflow;
    logic oflow;
  } dp_status_t;

  typedef struct packed {
    logic ld_in;
    logic ld_op;
    logic init;
    logic shift_a;
    logic iter;
    logic rnd;
    logic inc_exp;
    logic ld_out;
    res_t res;
  } cu_ctrl_t;

endpackage

// File: rtl/fpdiv_if.sv
// Request/result bundle of the divider.
// The requester drives start and operands; the divider returns done, q and flags.
interface fpdiv_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [31:0] q;
  logic        uf;
  logic        of;
  logic        nanf;
  logic        inff;
  logic        dnf;
  logic        zf;
  logic        dzf;

  modport master (
    output start, a, b,
    input  done, q, uf, of, nanf, inff, dnf, zf, dzf
  );

  modport slave (
    input  start, a, b,
    output done, q, uf, of, nanf, inff, dnf, zf, dzf
  );
endinterface

// File: rtl/fpdiv_cu.sv
// Control unit: sequences load, classify, align, iterate, round, pack.
// Also chooses which result the datapath latches into the output registers.
module fpdiv_cu
  import fp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  dp_status_t st,
  output cu_ctrl_t   ctl,
  output logic       done
);

  state_t state, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    ctl = '0;
    ctl.res = RES_NORM;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ctl.ld_in = 1'b1;
          nxt = LOAD;
        end
      end
      LOAD: begin
        ctl.ld_op = 1'b1;
        nxt = CHECK;
      end
      CHECK: begin
        // special operands skip the iteration entirely
        if (st.nan | st.inf | st.zero | st.divzero) begin
          ctl.ld_out = 1'b1;
          nxt = DONE;
          if (st.nan)          ctl.res = RES_NAN;
          else if (st.inf)     ctl.res = RES_INF;
          else if (st.divzero) ctl.res = RES_DZ;
          else                 ctl.res = RES_ZERO;
        end else begin
          nxt = ALIGN;
        end
      end
      ALIGN: begin
        ctl.init = 1'b1;
        ctl.shift_a = st.lt;
        nxt = DIV;
      end
      DIV: begin
        ctl.iter = 1'b1;
        if (st.cnt_zero) nxt = ROUND;
      end
      ROUND: begin
        ctl.rnd = 1'b1;
        ctl.inc_exp = st.carry;
        nxt = PACK;
      end
      PACK: begin
        ctl.ld_out = 1'b1;
        if (st.oflow)      ctl.res = RES_OF;
        else if (st.uflow) ctl.res = RES_UF;
        else               ctl.res = RES_NORM;
        nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fpdiv_dp.sv
// Datapath: operand unpack, restoring significand divider, RNE rounding.
// Output registers change only when the control unit asserts ld_out.
module fpdiv_dp
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cu_ctrl_t    ctl,
  output dp_status_t  st,
  output logic [31:0] q,
  output logic        uf,
  output logic        of,
  output logic        nanf,
  output logic        inff,
  output logic        dnf,
  output logic        zf,
  output logic        dzf
);

  localparam logic [7:0] EMAX = 8'(EXP_MAX);

  logic [31:0] ra, rb;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb;
  logic s, dn;
  logic [24:0] rem;
  logic [24:0] quo;
  logic [22:0] man;
  logic signed [9:0] ex;
  logic [4:0] cnt;
  logic [23:0] ma, mb, diff;
  logic ge, up;
  logic [24:0] sum;

  assign ma = {1'b1, fa};
  assign mb = {1'b1, fb};
  assign ge = rem >= {1'b0, mb};
  assign diff = 24'(rem - {1'b0, mb});
  // guard is quo[0]; sticky is any remainder bit left over
  assign up = quo[0] & ((|rem) | quo[1]);
  assign sum = {1'b0, quo[24:1]} + {24'd0, up};

  assign st.nan = (ea == EMAX && fa != '0)
               || (eb == EMAX && fb != '0)
               || (ea == 8'd0 && eb == 8'd0)
               || (ea == EMAX && eb == EMAX);
  assign st.inf = ea == EMAX;
  assign st.divzero = eb == 8'd0;
  assign st.zero = (ea == 8'd0) || (eb == EMAX);
  assign st.lt = ma < mb;
  assign st.cnt_zero = cnt == 5'd0;
  assign st.carry = sum[24];
  assign st.uflow = ex < 10'sd1;
  assign st.oflow = ex > 10'sd254;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      ea <= '0;
      eb <= '0;
      fa <= '0;
      fb <= '0;
      s <= 1'b0;
      dn <= 1'b0;
      rem <= '0;
      quo <= '0;
      man <= '0;
      ex <= '0;
      cnt <= '0;
    end else begin
      if (ctl.ld_in) begin
        ra <= a;
        rb <= b;
      end
      if (ctl.ld_op) begin
        s <= ra[31] ^ rb[31];
        ea <= ra[30:23];
        eb <= rb[30:23];
        // denormals collapse to signed zero here
        fa <= (ra[30:23] == 8'd0) ? '0 : ra[22:0];
        fb <= (rb[30:23] == 8'd0) ? '0 : rb[22:0];
        dn <= (ra[30:23] == 8'd0 && ra[22:0] != '0)
           || (rb[30:23] == 8'd0 && rb[22:0] != '0);
      end
      if (ctl.init) begin
        rem <= ctl.shift_a ? {ma, 1'b0} : {1'b0, ma};
        ex <= {2'b0, ea} - {2'b0, eb} + 10'(BIAS)
            - {9'd0, ctl.shift_a};
        quo <= '0;
        cnt <= 5'(ITER - 1);
      end
      if (ctl.iter) begin
        rem <= ge ? {diff, 1'b0} : {rem[23:0], 1'b0};
        quo <= {quo[23:0], ge};
        cnt <= cnt - 5'd1;
      end
      if (ctl.rnd) begin
        man <= sum[24] ? sum[23:1] : sum[22:0];
        if (ctl.inc_exp) ex <= ex + 10'sd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      uf <= 1'b0;
      of <= 1'b0;
      nanf <= 1'b0;
      inff <= 1'b0;
      dnf <= 1'b0;
      zf <= 1'b0;
      dzf <= 1'b0;
    end else if (ctl.ld_out) begin
      uf <= 1'b0;
      of <= 1'b0;
      nanf <= 1'b0;
      inff <= 1'b0;
      zf <= 1'b0;
      dzf <= 1'b0;
      dnf <= dn;
      unique case (ctl.res)
        RES_NAN: begin
          q <= QNAN;
          nanf <= 1'b1;
        end
        RES_INF: begin
          q <= POS_INF | {s, 31'd0};
          inff <= 1'b1;
        end
        RES_DZ: begin
          q <= POS_INF | {s, 31'd0};
          inff <= 1'b1;
          dzf <= 1'b1;
        end
        RES_ZERO: begin
          q <= {s, 31'd0};
          zf <= 1'b1;
        end
        RES_OF: begin
          q <= POS_INF | {s, 31'd0};
          of <= 1'b1;
          inff <= 1'b1;
        end
        RES_UF: begin
          q <= {s, 31'd0};
          uf <= 1'b1;
          zf <= 1'b1;
        end
        default: q <= {s, ex[7:0], man};
      endcase
    end
  end

endmodule

// File: rtl/fpdiv.sv
// Single-precision divider top: control unit plus datapath.
// Reset is asynchronous and aborts any operation in flight.
module fpdiv
  import fp_pkg::*;
(
  input logic   clk,
  input logic   rst,
  fpdiv_if.slave bus
);

  dp_status_t st;
  cu_ctrl_t   ctl;

  fpdiv_cu u_cu (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .st    (st),
    .ctl   (ctl),
    .done  (bus.done)
  );

  fpdiv_dp u_dp (
    .clk  (clk),
    .rst  (rst),
    .a    (bus.a),
    .b    (bus.b),
    .ctl  (ctl),
    .st   (st),
    .q    (bus.q),
    .uf   (bus.uf),
    .of   (bus.of),
    .nanf (bus.nanf),
    .inff (bus.inff),
    .dnf  (bus.dnf),
    .zf   (bus.zf),
    .dzf  (bus.dzf)
  );

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed vectors, random operands
// against an integer-arithmetic reference, back-to-back and reset abort.
module tb_fpdiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fpdiv_if bus ();

  fpdiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] flg;
  assign flg = {bus.uf, bus.of, bus.nanf, bus.inff,
                bus.dnf, bus.zf, bus.dzf};

  // flags packed as {uf, of, nanf, inff, dnf, zf, dzf}
  function automatic void ref_div(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [6:0]  f,
    output int          lat
  );
    int ea, eb, e;
    longint fa, fb, na, nb, num, qq, r, m;
    bit s, dn, g, stk, za, zb, ia, ib, xa, xb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    dn = (ea == 0 && fa != 0) || (eb == 0 && fb != 0);
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
    s = a[31] ^ b[31];
    za = ea == 0;
    zb = eb == 0;
    ia = ea == 255 && fa == 0;
    ib = eb == 255 && fb == 0;
    xa = ea == 255 && fa != 0;
    xb = eb == 255 && fb != 0;
    f = '0;
    f[2] = dn;
    lat = 3;
    if (xa || xb || (za && zb) || (ia && ib)) begin
      q = 32'h7FC00000;
      f[4] = 1'b1;
    end else if (ia) begin
      q = {s, 31'h7F800000};
      f[3] = 1'b1;
    end else if (zb) begin
      q = {s, 31'h7F800000};
      f[3] = 1'b1;
      f[0] = 1'b1;
    end else if (za || ib) begin
      q = {s, 31'd0};
      f[1] = 1'b1;
    end else begin
      lat = 31;
      na = (64'sd1 << 23) | fa;
      nb = (64'sd1 << 23) | fb;
      num = na << 30;
      qq = num / nb;
      r = num % nb;
      e = ea - eb + 127;
      if (qq >= (64'sd1 << 30)) begin
        m = qq >> 7;
        g = ((qq >> 6) & 1) != 0;
        stk = (qq & 63) != 0 || r != 0;
      end else begin
        e = e - 1;
        m = qq >> 6;
        g = ((qq >> 5) & 1) != 0;
        stk = (qq & 31) != 0 || r != 0;
      end
      if (g && (stk || (m & 1) != 0)) m = m + 1;
      if (m == (64'sd1 << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
      if (e > 254) begin
        q = {s, 31'h7F800000};
        f[5] = 1'b1;
        f[3] = 1'b1;
      end else if (e < 1) begin
        q = {s, 31'd0};
        f[6] = 1'b1;
        f[1] = 1'b1;
      end else begin
        q = {s, 8'(e), 23'(m)};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0: v[30:0] = '0;
      1: v[30:0] = 31'h7F800000;
      2: begin
        v[30:23] = 8'hFF;
        if (v[22:0] == '0) v[0] = 1'b1;
      end
      3: v[30:23] = 8'h00;
      4, 5: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'(107 + $urandom_range(0, 40));
    endcase
    return v;
  endfunction

  // one request; bounded wait for done, then one more edge
  task automatic do_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] q,
    output logic [6:0]  f,
    output logic        dnext,
    output logic [31:0] qh
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = bus.q;
    f = flg;
    @(posedge clk);
    #1;
    dnext = bus.done;
    qh = bus.q;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", bus.done);
    end
    checks++;
    if (bus.q !== 32'h0) begin
      errors++;
      $display("FAIL reset_q: got %h want 00000000", bus.q);
    end
    checks++;
    if (flg !== 7'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000", flg);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va [7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000,
      32'h00000000, 32'h7F000000, 32'h00800000, 32'h00000001};
    logic [31:0] vb [7] = '{32'h40000000, 32'h40400000, 32'h00000000,
      32'h80000000, 32'h3E800000, 32'h40000000, 32'h3F800000};
    logic [31:0] vq [7] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000,
      32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000};
    logic [6:0] vf [7] = '{7'b0000000, 7'b0000000, 7'b0001001,
      7'b0010000, 7'b0101000, 7'b1000010, 7'b0000110};
    int vl [7] = '{31, 31, 3, 3, 31, 31, 3};
    int lat;
    logic [31:0] q, qh;
    logic [6:0] f;
    logic dn;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], lat, q, f, dn, qh);
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, vl[i]);
      end
      checks++;
      if (q !== vq[i]) begin
        errors++;
        $display("FAIL dir%0d_q: got %h want %h", i, q, vq[i]);
      end
      checks++;
      if (f !== vf[i]) begin
        errors++;
        $display("FAIL dir%0d_flags: got %b want %b", i, f, vf[i]);
      end
      checks++;
      if (dn !== 1'b0 || qh !== vq[i]) begin
        errors++;
        $display("FAIL dir%0d_pulse_hold: got done=%b q=%h want 0 %h",
                 i, dn, qh, vq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, qh, eq;
    logic [6:0] f, ef;
    int lat, el;
    logic dn;
    for (int i = 0; i < 80; i++) begin
      a = rand_fp();
      b = rand_fp();
      ref_div(a, b, eq, ef, el);
      do_op(a, b, lat, q, f, dn, qh);
      checks++;
      if (lat != el) begin
        errors++;
        $display("FAIL rnd_latency %h/%h: got %0d want %0d", a, b, lat, el);
      end
      checks++;
      if (q !== eq) begin
        errors++;
        $display("FAIL rnd_q %h/%h: got %h want %h", a, b, q, eq);
      end
      checks++;
      if (f !== ef) begin
        errors++;
        $display("FAIL rnd_flags %h/%h: got %b want %b", a, b, f, ef);
      end
      checks++;
      if (dn !== 1'b0 || qh !== eq) begin
        errors++;
        $display("FAIL rnd_pulse_hold: got done=%b q=%h want 0 %h",
                 dn, qh, eq);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd = 0;
    int de [3] = '{0, 0, 0};
    logic [31:0] dq [3];
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    for (int e = 1; e <= 96; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (nd < 3) begin
          de[nd] = e;
          dq[nd] = bus.q;
        end
        nd++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (nd != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 3", nd);
    end
    for (int i = 0; i < 3 && i < nd; i++) begin
      checks++;
      if (de[i] != 31 + 32 * i || dq[i] !== 32'h3EAAAAAB) begin
        errors++;
        $display("FAIL b2b_op%0d: got edge %0d q %h want edge %0d q %h",
                 i, de[i], dq[i], 31 + 32 * i, 32'h3EAAAAAB);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_ignored();
    int nd = 0;
    int de = 0;
    logic [31:0] dq = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        nd++;
        de = e;
        dq = bus.q;
      end
      if (e < 25) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a = $urandom;
        bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (nd != 1 || de != 31) begin
      errors++;
      $display("FAIL ignore_start: got %0d done at edge %0d want 1 at 31",
               nd, de);
    end
    checks++;
    if (dq !== 32'h40400000) begin
      errors++;
      $display("FAIL ignore_start_q: got %h want 40400000", dq);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    logic [31:0] q, qh;
    logic [6:0] f;
    logic dn;
    do_op(32'h7F000000, 32'h3E800000, lat, q, f, dn, qh);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 32'h0 || flg !== 7'h0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got q=%h flags=%b done=%b want 0",
               bus.q, flg, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d want 0", nd);
    end
    do_op(32'hC0C00000, 32'h40000000, lat, q, f, dn, qh);
    checks++;
    if (lat != 31) begin
      errors++;
      $display("FAIL midrst_latency: got %0d want 31", lat);
    end
    checks++;
    if (q !== 32'hC0400000 || f !== 7'h0) begin
      errors++;
      $display("FAIL midrst_q: got %h %b want c0400000 0000000", q, f);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
